// File: rtl/step_pulse_conditioner.sv
// step_pulse_conditioner
//
// Turns the raw, asynchronous, bouncy pedometer contact into clean one-cycle
// step pulses for the downstream step counter. A step is accepted only after
// its level has been stable for DEBOUNCE_CYCLES. Steps arriving within
// LOCKOUT_CYCLES of the previous accepted pulse are counted as rejects.
// Cadence (accepted pulses per CLK_HZ-cycle window) is reported for the
// display path.
//
// Optional build macro: SELFTEST_GEN_EN
//   When defined, adds input selfTest and parameter SELFTEST_PERIOD. While
//   selfTest is high, an internal square wave of that period replaces the
//   synchronized contact at the debounce FSM input.
//
// Ports:
//   clk100Mhz    in   system clock, all logic on posedge
//   rst          in   synchronous, active-high reset
//   rawStep      in   asynchronous raw step contact, active high
//   enable       in   low: qualified steps neither pulse nor count as rejects
//   selfTest     in   (SELFTEST_GEN_EN only) select internal test waveform
//   pulseSignal  out  registered one-cycle pulse per accepted step
//   stepHeld     out  debounced contact level (HIGH or FALL_CHK)
//   cadence      out  accepted pulses in last completed window, saturating
//   cadenceValid out  one-cycle strobe, high in the cycle cadence takes a new value
//   rejectCount  out  steps rejected by lockout, saturating at all-ones
//
// Handshake: pulseSignal and cadenceValid are single-cycle strobes with no
// ready/back-pressure; the consumer must sample them every cycle. cadence is
// valid to read whenever cadenceValid is high and holds until the next strobe.
//
// Debug visibility: the debounce FSM state is the signal `state` (state_t).

module step_pulse_conditioner #(
    parameter int CLK_HZ          = 100000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LOCKOUT_CYCLES  = 20000000,
    parameter int CNT_W           = 8
`ifdef SELFTEST_GEN_EN
    ,
    parameter int SELFTEST_PERIOD = 50000000
`endif
) (
    input  logic             clk100Mhz,
    input  logic             rst,
    input  logic             rawStep,
    input  logic             enable,
`ifdef SELFTEST_GEN_EN
    input  logic             selfTest,
`endif
    output logic             pulseSignal,
    output logic             stepHeld,
    output logic [CNT_W-1:0] cadence,
    output logic             cadenceValid,
    output logic [CNT_W-1:0] rejectCount
);

    localparam int DBW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LCKW  = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
    localparam int WINW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCKW-1:0]  LOCK_LOAD = LCKW'(LOCKOUT_CYCLES);
    localparam logic [WINW-1:0]  WIN_LAST  = WINW'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } state_t;

    // Two-flop synchronizer on the asynchronous contact.
    logic sync_a;
    logic syncStep;

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            sync_a   <= 1'b0;
            syncStep <= 1'b0;
        end else begin
            sync_a   <= rawStep;
            syncStep <= sync_a;
        end
    end

    logic fsm_in;

`ifdef SELFTEST_GEN_EN
    localparam int STW = (SELFTEST_PERIOD > 1) ? $clog2(SELFTEST_PERIOD) : 1;
    localparam logic [STW-1:0] ST_LAST = STW'(SELFTEST_PERIOD - 1);
    localparam logic [STW-1:0] ST_HALF = STW'(SELFTEST_PERIOD / 2);

    logic [STW-1:0] st_phase;

    // Phase restarts whenever the generator is deselected so each self-test
    // run begins with a fresh high half-period.
    always_ff @(posedge clk100Mhz) begin
        if (rst || !selfTest) begin
            st_phase <= '0;
        end else if (st_phase == ST_LAST) begin
            st_phase <= '0;
        end else begin
            st_phase <= st_phase + 1'b1;
        end
    end

    assign fsm_in = selfTest ? (st_phase < ST_HALF) : syncStep;
`else
    assign fsm_in = syncStep;
`endif

    // Debounce FSM
    state_t         state;
    state_t         state_nxt;
    logic [DBW-1:0] cnt;
    logic [DBW-1:0] cnt_nxt;
    logic           qualify;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        qualify   = 1'b0;
        case (state)
            LOW: begin
                if (fsm_in) begin
                    state_nxt = RISE_CHK;
                    cnt_nxt   = '0;
                end
            end
            RISE_CHK: begin
                if (!fsm_in) begin
                    state_nxt = LOW;
                end else if (cnt == DB_LAST) begin
                    state_nxt = HIGH;
                    qualify   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (!fsm_in) begin
                    state_nxt = FALL_CHK;
                    cnt_nxt   = '0;
                end
            end
            FALL_CHK: begin
                if (fsm_in) begin
                    state_nxt = HIGH;
                end else if (cnt == DB_LAST) begin
                    state_nxt = LOW;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = LOW;
        endcase
    end

    // Qualification against enable and the lockout window
    logic [LCKW-1:0] lockout;
    logic            lock_idle;
    logic            accept;
    logic            reject;

    assign lock_idle = (lockout == '0);
    assign accept    = qualify && enable && lock_idle;
    assign reject    = qualify && enable && !lock_idle;

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            state       <= LOW;
            cnt         <= '0;
            stepHeld    <= 1'b0;
            pulseSignal <= 1'b0;
            lockout     <= '0;
            rejectCount <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            // Registered alongside the state so it tracks HIGH/FALL_CHK exactly.
            stepHeld    <= (state_nxt == HIGH) || (state_nxt == FALL_CHK);
            pulseSignal <= accept;
            // A fresh accept reloads; a rejected step leaves the window running.
            if (accept) begin
                lockout <= LOCK_LOAD;
            end else if (!lock_idle) begin
                lockout <= lockout - 1'b1;
            end
            if (reject && (rejectCount != CNT_MAX)) begin
                rejectCount <= rejectCount + 1'b1;
            end
        end
    end

    // Cadence window
    logic [WINW-1:0]  window;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;

    // Includes a pulse present in the current cycle, so a pulse on the last
    // window cycle lands in the window that is closing.
    assign acc_inc = (pulseSignal && (acc != CNT_MAX)) ? acc + 1'b1 : acc;

    always_ff @(posedge clk100Mhz) begin
        if (rst) begin
            window       <= '0;
            acc          <= '0;
            cadence      <= '0;
            cadenceValid <= 1'b0;
        end else begin
            cadenceValid <= (window == WIN_LAST);
            if (window == WIN_LAST) begin
                window  <= '0;
                cadence <= acc_inc;
                acc     <= '0;
            end else begin
                window <= window + 1'b1;
                acc    <= acc_inc;
            end
        end
    end

endmodule

// File: tb/tb_step_pulse_conditioner.sv
`timescale 1ns/1ps
module tb_step_pulse_conditioner;

    localparam int CLK_HZ = 100;
    localparam int DB     = 4;
    localparam int LO     = 20;
    localparam int W      = 8;
    localparam int SW     = 2;

    // Clock / reset
    logic clk100Mhz = 1'b0;
    logic rst       = 1'b1;
    logic rawStep   = 1'b0;
    logic enable    = 1'b1;

    always #5 clk100Mhz = ~clk100Mhz;

    // Cycle index since reset release: during cycle c, cyc == c and the
    // DUT window counter equals c mod CLK_HZ.
    int cyc = 0;
    always @(posedge clk100Mhz) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Main DUT
    logic         pulseSignal, stepHeld, cadenceValid;
    logic [W-1:0] cadence, rejectCount;

    step_pulse_conditioner #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LO), .CNT_W(W)
    ) dut (
        .clk100Mhz(clk100Mhz), .rst(rst), .rawStep(rawStep), .enable(enable),
        .pulseSignal(pulseSignal), .stepHeld(stepHeld), .cadence(cadence),
        .cadenceValid(cadenceValid), .rejectCount(rejectCount)
    );

    // Narrow-counter instances for saturation checks
    logic          s0_pulse, s0_held, s0_cv;
    logic [SW-1:0] s0_cad, s0_rej;
    logic          s20_pulse, s20_held, s20_cv;
    logic [SW-1:0] s20_cad, s20_rej;

    step_pulse_conditioner #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(0), .CNT_W(SW)
    ) dut_s0 (
        .clk100Mhz(clk100Mhz), .rst(rst), .rawStep(rawStep), .enable(enable),
        .pulseSignal(s0_pulse), .stepHeld(s0_held), .cadence(s0_cad),
        .cadenceValid(s0_cv), .rejectCount(s0_rej)
    );

    step_pulse_conditioner #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .LOCKOUT_CYCLES(LO), .CNT_W(SW)
    ) dut_s20 (
        .clk100Mhz(clk100Mhz), .rst(rst), .rawStep(rawStep), .enable(enable),
        .pulseSignal(s20_pulse), .stepHeld(s20_held), .cadence(s20_cad),
        .cadenceValid(s20_cv), .rejectCount(s20_rej)
    );

    // Scoreboard
    int           n_checks = 0;
    int           n_fail   = 0;
    int           pulse_q[$];   // expected cycle index of each main-DUT pulse
    logic [W-1:0] exp_q[$];     // expected cadence value at each strobe

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops and compares whenever the main DUT presents a strobe.
    always @(negedge clk100Mhz) begin
        if (pulseSignal === 1'b1) begin
            if (pulse_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: pulse at cycle %0d, none expected", cyc);
            end else begin
                check("pulse_cycle", cyc, pulse_q.pop_front());
            end
        end
        if (cadenceValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cadence: strobe at cycle %0d value %0d, none expected", cyc, cadence);
            end else begin
                check("cadence", cadence, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic wait_to(input int n);
        int guard = 0;
        while (cyc < n && guard < 20000) begin
            @(posedge clk100Mhz);
            #1;
            guard++;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        rawStep = 1'b0;
        enable  = 1'b1;
        repeat (2) @(posedge clk100Mhz);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_pulse"},   pulseSignal,  0);
        check({tag, "_held"},    stepHeld,     0);
        check({tag, "_cadence"}, cadence,      0);
        check({tag, "_cvalid"},  cadenceValid, 0);
        check({tag, "_reject"},  rejectCount,  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Segment A: latency, lockout reject, glitches, enable low
        do_reset();
        check_idle("reset");
        pulse_q.push_back(12);
        pulse_q.push_back(47);
        pulse_q.push_back(77);
        exp_q.push_back(3);
        exp_q.push_back(0);

        wait_to(5);   rawStep = 1'b1;
        wait_to(11);  check("held_before_rise", stepHeld, 0);
        wait_to(12);  check("held_rise", stepHeld, 1);
        wait_to(15);  rawStep = 1'b0;
        wait_to(21);  check("held_before_fall", stepHeld, 1);
        wait_to(22);  check("held_fall", stepHeld, 0);

        wait_to(40);  rawStep = 1'b1;
        wait_to(46);  rawStep = 1'b0;
        wait_to(52);  rawStep = 1'b1;
        wait_to(58);  rawStep = 1'b0;
        wait_to(60);  check("reject_one", rejectCount, 1);
        wait_to(70);  rawStep = 1'b1;
        wait_to(76);  rawStep = 1'b0;

        for (int g = 0; g < 5; g++) begin
            wait_to(110 + 5 * g);      rawStep = 1'b1;
            check("glitch_held_a", stepHeld, 0);
            wait_to(110 + 5 * g + 3);  rawStep = 1'b0;
            check("glitch_held_b", stepHeld, 0);
        end
        wait_to(145); check("glitch_held_end", stepHeld, 0);

        wait_to(148); enable = 1'b0;
        wait_to(150); rawStep = 1'b1;
        wait_to(157); check("disabled_held", stepHeld, 1);
        wait_to(160); rawStep = 1'b0;
        wait_to(170); check("disabled_reject", rejectCount, 1);
        enable = 1'b1;
        wait_to(205);

        // Segment B: five pulses in window 0, boundary pulse on window==99
        do_reset();
        for (int i = 0; i < 5; i++) pulse_q.push_back(22 * i + 7);
        pulse_q.push_back(157);
        pulse_q.push_back(199);
        exp_q.push_back(5);
        exp_q.push_back(2);
        exp_q.push_back(0);
        for (int i = 0; i < 5; i++) begin
            wait_to(22 * i);      rawStep = 1'b1;
            wait_to(22 * i + 6);  rawStep = 1'b0;
        end
        wait_to(150); rawStep = 1'b1;
        wait_to(156); rawStep = 1'b0;
        wait_to(192); rawStep = 1'b1;
        wait_to(198); rawStep = 1'b0;
        wait_to(305);

        // Segment D: reset during RISE_CHK abandons the step
        do_reset();
        wait_to(5);   rawStep = 1'b1;
        wait_to(9);
        do_reset();
        check_idle("midreset");
        exp_q.push_back(0);
        wait_to(105);

        // Segment E: six quick steps, saturation on narrow counters
        do_reset();
        pulse_q.push_back(7);
        pulse_q.push_back(37);
        exp_q.push_back(2);
        for (int i = 0; i < 6; i++) begin
            wait_to(10 * i);      rawStep = 1'b1;
            wait_to(10 * i + 5);  rawStep = 1'b0;
        end
        wait_to(60);
        check("reject_four", rejectCount, 4);
        check("s20_reject_sat", s20_rej, 3);
        check("s0_reject_none", s0_rej, 0);
        wait_to(100);
        check("s0_cvalid", s0_cv, 1);
        check("s0_cadence_sat", s0_cad, 3);
        check("s20_cadence", s20_cad, 2);
        wait_to(102);

        check("pulse_q_drained", pulse_q.size(), 0);
        check("cadence_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
